// File: rtl/lcd_mode_sequencer.sv
// Dot-timing controller for the LCD pixel path: PPU mode sequence, line counter,
// pixel strobe, LYC coincidence and STAT/VBLANK interrupt pulses.
module lcd_mode_sequencer #(
    parameter int unsigned DOTS_PER_LINE = 456,
    parameter int unsigned LINES         = 154,
    parameter int unsigned VIS_LINES     = 144,
    parameter int unsigned OAM_DOTS      = 80,
    parameter int unsigned XFER_BASE     = 172,
    parameter int unsigned H_PIXELS      = 160
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk4_en,
    input  logic       lcd_on,
    input  logic [2:0] scx_fine,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_en,
    output logic [1:0] mode,
    output logic [7:0] ly,
    output logic       pix_en,
    output logic       lyc_match,
    output logic       stat_irq,
    output logic       vblank_irq
);

    typedef enum logic [1:0] {
        ModeHblank = 2'b00,
        ModeVblank = 2'b01,
        ModeOam    = 2'b10,
        ModeXfer   = 2'b11
    } mode_e;

    localparam logic [8:0] DotLast  = 9'(DOTS_PER_LINE - 1);
    localparam logic [7:0] LyLast   = 8'(LINES - 1);
    localparam logic [7:0] LyVis    = 8'(VIS_LINES);
    localparam logic [8:0] OamEnd   = 9'(OAM_DOTS);
    localparam logic [9:0] XferEnd0 = 10'(OAM_DOTS + XFER_BASE);
    localparam logic [9:0] HPix     = 10'(H_PIXELS);

    logic       r_run;
    logic [8:0] r_dot;
    logic [7:0] r_ly;
    logic [2:0] r_scx;
    mode_e      r_mode;
    logic       r_pix;
    logic       r_lyc;
    logic       r_stat_line;
    logic       r_stat_irq;
    logic       r_vb_irq;

    logic [8:0] w_dot_nx;
    logic [7:0] w_ly_nx;
    logic [2:0] w_s;
    logic [9:0] w_xfer_end;
    logic [9:0] w_pix_start;
    logic [9:0] w_dot_ext;
    logic       w_vis;
    mode_e      w_mode_nx;
    logic       w_pix_nx;
    logic       w_lyc_nx;
    logic       w_stat_nx;

    // First enable after a (re)start lands on dot 0 of line 0 instead of advancing.
    always_comb begin
        w_dot_nx = '0;
        w_ly_nx  = '0;
        if (r_run) begin
            if (r_dot == DotLast) begin
                w_dot_nx = '0;
                w_ly_nx  = (r_ly == LyLast) ? 8'd0 : r_ly + 8'd1;
            end else begin
                w_dot_nx = r_dot + 9'd1;
                w_ly_nx  = r_ly;
            end
        end
    end

    always_comb begin
        w_s         = (w_dot_nx == OamEnd) ? scx_fine : r_scx;
        w_xfer_end  = XferEnd0 + {7'd0, w_s};
        w_pix_start = w_xfer_end - HPix;
        w_dot_ext   = {1'b0, w_dot_nx};
        w_vis       = (w_ly_nx < LyVis);

        w_mode_nx = ModeHblank;
        if (!w_vis) begin
            w_mode_nx = ModeVblank;
        end else if (w_dot_nx < OamEnd) begin
            w_mode_nx = ModeOam;
        end else if (w_dot_ext < w_xfer_end) begin
            w_mode_nx = ModeXfer;
        end

        w_pix_nx  = w_vis && (w_dot_ext >= w_pix_start) && (w_dot_ext < w_xfer_end);
        w_lyc_nx  = (w_ly_nx == lyc);
        w_stat_nx = (w_lyc_nx && stat_en[3]) ||
                    ((w_mode_nx == ModeOam)    && stat_en[2]) ||
                    ((w_mode_nx == ModeVblank) && stat_en[1]) ||
                    ((w_mode_nx == ModeHblank) && stat_en[0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run       <= 1'b0;
            r_dot       <= '0;
            r_ly        <= '0;
            r_scx       <= '0;
            r_mode      <= ModeHblank;
            r_pix       <= 1'b0;
            r_lyc       <= 1'b0;
            r_stat_line <= 1'b0;
            r_stat_irq  <= 1'b0;
            r_vb_irq    <= 1'b0;
        end else if (!lcd_on) begin
            r_run       <= 1'b0;
            r_dot       <= '0;
            r_ly        <= '0;
            r_mode      <= ModeHblank;
            r_pix       <= 1'b0;
            r_lyc       <= 1'b0;
            r_stat_line <= 1'b0;
            r_stat_irq  <= 1'b0;
            r_vb_irq    <= 1'b0;
        end else if (clk4_en) begin
            r_run       <= 1'b1;
            r_dot       <= w_dot_nx;
            r_ly        <= w_ly_nx;
            if (w_dot_nx == OamEnd) begin
                r_scx <= scx_fine;
            end
            r_mode      <= w_mode_nx;
            r_pix       <= w_pix_nx;
            r_lyc       <= w_lyc_nx;
            r_stat_line <= w_stat_nx;
            r_stat_irq  <= w_stat_nx & ~r_stat_line;
            r_vb_irq    <= r_run && (w_dot_nx == 9'd0) && (w_ly_nx == LyVis);
        end else begin
            r_stat_irq <= 1'b0;
            r_vb_irq   <= 1'b0;
        end
    end

    assign mode       = r_mode;
    assign ly         = r_ly;
    assign pix_en     = r_pix;
    assign lyc_match  = r_lyc;
    assign stat_irq   = r_stat_irq;
    assign vblank_irq = r_vb_irq;

endmodule

// File: tb/tb_lcd_mode_sequencer.sv
// Bench for lcd_mode_sequencer: frame-position reference model checked every cycle,
// plus literal timing expectations and randomized enable/lcd_on/register traffic.
module tb_lcd_mode_sequencer;

    localparam int Frame = 70224;
    localparam int Dpl   = 456;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clk4_en;
    logic       lcd_on;
    logic [2:0] scx_fine;
    logic [7:0] lyc;
    logic [3:0] stat_en;
    logic [1:0] mode;
    logic [7:0] ly;
    logic       pix_en;
    logic       lyc_match;
    logic       stat_irq;
    logic       vblank_irq;

    lcd_mode_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk4_en    (clk4_en),
        .lcd_on     (lcd_on),
        .scx_fine   (scx_fine),
        .lyc        (lyc),
        .stat_en    (stat_en),
        .mode       (mode),
        .ly         (ly),
        .pix_en     (pix_en),
        .lyc_match  (lyc_match),
        .stat_irq   (stat_irq),
        .vblank_irq (vblank_irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: position within the frame, not dot/line counters.
    int m_run, m_pos, m_s, m_line;
    int e_mode, e_ly, e_pix, e_lyc, e_stat, e_vb;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_s = 0; m_line = 0;
        e_mode = 0; e_ly = 0; e_pix = 0; e_lyc = 0; e_stat = 0; e_vb = 0;
    endtask

    task automatic model_update();
        int dot, lnum, vis, line;
        if (!lcd_on) begin
            m_run = 0; m_pos = 0; m_line = 0;
            e_mode = 0; e_ly = 0; e_pix = 0; e_lyc = 0; e_stat = 0; e_vb = 0;
        end else if (clk4_en) begin
            if (m_run != 0) m_pos = (m_pos + 1) % Frame;
            else begin
                m_run = 1;
                m_pos = 0;
            end
            lnum = m_pos / Dpl;
            dot  = m_pos % Dpl;
            if (dot == 80) m_s = int'(scx_fine);
            vis = (lnum < 144) ? 1 : 0;
            if (vis == 0)             e_mode = 1;
            else if (dot < 80)        e_mode = 2;
            else if (dot < 252 + m_s) e_mode = 3;
            else                      e_mode = 0;
            e_pix = (vis != 0 && dot >= 92 + m_s && dot <= 251 + m_s) ? 1 : 0;
            e_ly  = lnum;
            e_lyc = (lnum == int'(lyc)) ? 1 : 0;
            line = ((e_lyc == 1 && stat_en[3]) || (e_mode == 2 && stat_en[2]) ||
                    (e_mode == 1 && stat_en[1]) || (e_mode == 0 && stat_en[0])) ? 1 : 0;
            e_stat = (line == 1 && m_line == 0) ? 1 : 0;
            m_line = line;
            e_vb   = (m_pos == 144 * Dpl) ? 1 : 0;
        end else begin
            e_stat = 0;
            e_vb   = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_update();
    endtask

    always @(negedge clk) begin
        check("mode",       int'(mode),       e_mode);
        check("ly",         int'(ly),         e_ly);
        check("pix_en",     int'(pix_en),     e_pix);
        check("lyc_match",  int'(lyc_match),  e_lyc);
        check("stat_irq",   int'(stat_irq),   e_stat);
        check("vblank_irq", int'(vblank_irq), e_vb);
    end

    int d_x[3], m_x[3], d_p[3], m_p[3];
    int first_pix1, d_stat_cnt, m_stat_cnt, d_vb_cnt, vb_at;
    int off_cnt, hold;

    initial begin
        reset_n = 1'b0; clk4_en = 1'b0; lcd_on = 1'b0;
        scx_fine = 3'd0; lyc = 8'd10; stat_en = 4'b1000;
        model_reset();
        repeat (3) tick();
        #1;
        check("reset_mode", int'(mode), 0);
        check("reset_ly",   int'(ly),   0);
        reset_n = 1'b1;
        lcd_on  = 1'b1;
        clk4_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_x[i] = 0; m_x[i] = 0; d_p[i] = 0; m_p[i] = 0;
        end
        first_pix1 = -1; d_stat_cnt = 0; m_stat_cnt = 0; d_vb_cnt = 0; vb_at = -1;

        // Enable every clock: edge k lands on frame position k.
        for (int k = 0; k < Frame + 100; k++) begin
            scx_fine = (k < Dpl) ? 3'd0 : (k < Dpl + 100) ? 3'd5 : 3'd2;
            if (k > 50 * Dpl) begin
                lyc = 8'd143; stat_en = 4'b1001;
            end
            tick();
            #1;
            if (k < 3 * Dpl) begin
                d_x[k / Dpl] += (mode == 2'b11) ? 1 : 0;
                m_x[k / Dpl] += (e_mode == 3) ? 1 : 0;
                d_p[k / Dpl] += int'(pix_en);
                m_p[k / Dpl] += e_pix;
                if (k >= Dpl && k < 2 * Dpl && pix_en && first_pix1 < 0) first_pix1 = k - Dpl;
            end
            if (k < Frame) begin
                d_stat_cnt += int'(stat_irq);
                m_stat_cnt += e_stat;
                d_vb_cnt   += int'(vblank_irq);
                if (vblank_irq && vb_at < 0) vb_at = k;
            end
            if (k == 0)       check("line0_start_mode", int'(mode), 2);
            if (k == 144 * Dpl) begin
                check("vblank_ly",   int'(ly),   144);
                check("vblank_mode", int'(mode), 1);
            end
            if (k == Frame) begin
                check("wrap_ly",   int'(ly),   0);
                check("wrap_mode", int'(mode), 2);
            end
        end
        check("xfer_len_scx0",   d_x[0], 172);
        check("model_xfer_scx0", m_x[0], 172);
        check("pix_cnt_scx0",    d_p[0], 160);
        check("model_pix_scx0",  m_p[0], 160);
        check("xfer_len_scx5",   d_x[1], 177);
        check("model_xfer_scx5", m_x[1], 177);
        check("pix_cnt_scx5",    d_p[1], 160);
        check("pix_first_scx5",  first_pix1, 97);
        check("xfer_len_scx2",   d_x[2], 174);
        check("stat_pulses",     d_stat_cnt, 94);
        check("model_stat",      m_stat_cnt, 94);
        check("vblank_count",    d_vb_cnt, 1);
        check("vblank_pos",      vb_at, 144 * Dpl);

        // lcd_on drop mid-transfer, with no dot enable present.
        lcd_on = 1'b0; clk4_en = 1'b0;
        tick(); #1;
        check("off_mode", int'(mode), 0);
        check("off_ly",   int'(ly),   0);
        check("off_pix",  int'(pix_en), 0);
        repeat (5) begin tick(); #1; end
        lcd_on = 1'b1;
        tick(); #1;
        check("on_wait_mode", int'(mode), 0);
        clk4_en = 1'b1;
        tick(); #1;
        check("restart_mode", int'(mode), 2);
        check("restart_ly",   int'(ly),   0);

        off_cnt = 0; hold = 0;
        for (int i = 0; i < 9000; i++) begin
            if (i == 3000) hold = 100;
            if (hold > 0) begin
                clk4_en = 1'b0;
                hold--;
            end else begin
                clk4_en = ($urandom_range(3) != 0);
            end
            if (off_cnt > 0) begin
                lcd_on = 1'b0;
                off_cnt--;
            end else begin
                lcd_on = 1'b1;
                if ($urandom_range(1499) == 0) off_cnt = $urandom_range(20, 1);
            end
            if (i % 37 == 0)  scx_fine = 3'($urandom_range(7));
            if (i % 500 == 0) lyc = 8'($urandom_range(12));
            if (i % 300 == 0) stat_en = 4'($urandom_range(15));
            tick();
            #1;
            if (i == 5000) begin
                reset_n = 1'b0;
                model_reset();
                repeat (3) begin tick(); #1; end
                reset_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
